// File: rtl/mc_controller.sv
// Multicycle control FSM for the RV32 subset datapath: sequences mux selects, write strobes and ALU op per instruction.
// Outputs are combinational from state/op/memready/btaken; FETCH, MEMREAD and MEMWRITE hold while memready is low.
module mc_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        btaken,
    input  logic        memready,
    output logic [3:0]  alucontrol,
    output logic [1:0]  alusrca,
    output logic [1:0]  alusrcb,
    output logic [1:0]  resultsrc,
    output logic [1:0]  immsrc,
    output logic        adrsrc,
    output logic        irwrite,
    output logic        pcwrite,
    output logic        regwrite,
    output logic        memwrite,
    output logic        illegal,
    output logic        retire,
    output logic [31:0] instret
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;
    localparam logic [3:0] ALU_SLT = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL, S_ILLEGAL
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] instret_q, instret_d;
    logic [3:0]  dec_alu;
    logic        dec_ok;

    always_comb begin
        dec_ok  = 1'b1;
        dec_alu = ALU_ADD;
        case (funct3)
            3'b000:  dec_alu = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  dec_alu = ALU_SLT;
            3'b110:  dec_alu = ALU_OR;
            3'b111:  dec_alu = ALU_AND;
            default: dec_ok  = 1'b0;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   immsrc = 2'b01;
            OP_BEQ:  immsrc = 2'b10;
            OP_JAL:  immsrc = 2'b11;
            default: immsrc = 2'b00;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        alucontrol = ALU_ADD;
        alusrca    = 2'b00;
        alusrcb    = 2'b00;
        resultsrc  = 2'b00;
        adrsrc     = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        regwrite   = 1'b0;
        memwrite   = 1'b0;
        illegal    = 1'b0;
        retire     = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                irwrite   = memready;
                pcwrite   = memready;
                if (memready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = dec_ok ? S_EXECUTER : S_ILLEGAL;
                    OP_I:         state_d = dec_ok ? S_EXECUTEI : S_ILLEGAL;
                    OP_BEQ:       state_d = (funct3 == 3'b000) ? S_BEQ : S_ILLEGAL;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adrsrc = 1'b1;
                if (memready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                resultsrc = 2'b01;
                regwrite  = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                adrsrc   = 1'b1;
                memwrite = 1'b1;
                retire   = memready;
                if (memready) state_d = S_FETCH;
            end
            S_EXECUTER: begin
                alusrca    = 2'b10;
                alucontrol = dec_alu;
                state_d    = S_ALUWB;
            end
            S_EXECUTEI: begin
                alusrca    = 2'b10;
                alusrcb    = 2'b01;
                alucontrol = dec_alu;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQ: begin
                alusrca = 2'b10;
                pcwrite = btaken;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_JAL: begin
                alusrca = 2'b01;
                alusrcb = 2'b10;
                pcwrite = 1'b1;
                state_d = S_ALUWB;
            end
            S_ILLEGAL: illegal = 1'b1;
            default:   state_d = S_FETCH;
        endcase
        // State already sits in FETCH during reset; only the memready-driven strobes need masking.
        if (reset) begin
            irwrite  = 1'b0;
            pcwrite  = 1'b0;
            regwrite = 1'b0;
            memwrite = 1'b0;
            illegal  = 1'b0;
            retire   = 1'b0;
        end
    end

    always_comb begin
        instret_d = instret_q + {31'd0, retire};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-cycle expected outputs are queued with the stimulus, then popped and compared.
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        btaken;
    logic        memready;
    logic [3:0]  alucontrol;
    logic [1:0]  alusrca, alusrcb, resultsrc, immsrc;
    logic        adrsrc, irwrite, pcwrite, regwrite, memwrite, illegal, retire;
    logic [31:0] instret;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .btaken(btaken), .memready(memready), .alucontrol(alucontrol),
        .alusrca(alusrca), .alusrcb(alusrcb), .resultsrc(resultsrc), .immsrc(immsrc),
        .adrsrc(adrsrc), .irwrite(irwrite), .pcwrite(pcwrite), .regwrite(regwrite),
        .memwrite(memwrite), .illegal(illegal), .retire(retire), .instret(instret)
    );

    typedef struct packed {
        logic [3:0] alu;
        logic [1:0] sa, sb, rs, imm;
        logic       adr, irw, pcw, rw, mw, ret, ill;
    } obs_t;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_JAL = 5, K_ILL = 6, K_MWX = 7;

    obs_t        exp_q[$];
    logic [1:0]  stim_q[$];
    logic [31:0] cnt_q[$];
    logic [31:0] model_cnt;
    logic [1:0]  cur_imm;
    int          errors = 0;
    int          checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic obs_t mk(int alu, int sa, int sb, int rs, int adr, int irw, int pcw,
                                int rw, int mw, int ret, int ill);
        mk = {4'(alu), 2'(sa), 2'(sb), 2'(rs), cur_imm, 1'(adr), 1'(irw), 1'(pcw),
              1'(rw), 1'(mw), 1'(ret), 1'(ill)};
    endfunction

    function automatic obs_t obs_now();
        obs_now = {alucontrol, alusrca, alusrcb, resultsrc, immsrc, adrsrc, irwrite, pcwrite,
                   regwrite, memwrite, retire, illegal};
    endfunction

    function automatic logic rb();
        rb = 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input obs_t e, input logic mr, input logic bt);
        exp_q.push_back(e);
        stim_q.push_back({mr, bt});
        cnt_q.push_back(model_cnt);
        if (e.ret) model_cnt = model_cnt + 32'd1;
    endtask

    task automatic drain(input string name, input logic [6:0] o, input logic [2:0] f3, input logic f7);
        obs_t        e;
        logic [1:0]  s;
        logic [31:0] c;
        int          n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            s = stim_q.pop_front();
            c = cnt_q.pop_front();
            @(negedge clk);
            op = o; funct3 = f3; funct7b5 = f7;
            memready = s[1]; btaken = s[0];
            #1;
            check_eq($sformatf("%s_c%0d_out", name, n), 32'(obs_now()), 32'(e));
            check_eq($sformatf("%s_c%0d_cnt", name, n), instret, c);
            n++;
        end
    endtask

    task automatic run(input string name, input int kind, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input int ealu, input logic bt, input int fst, input int mst);
        case (kind)
            K_SW, K_MWX: cur_imm = 2'b01;
            K_BEQ:       cur_imm = 2'b10;
            K_JAL:       cur_imm = 2'b11;
            default:     cur_imm = 2'b00;
        endcase
        for (int i = 0; i < fst; i++) push(mk(0, 0, 2, 2, 0, 0, 0, 0, 0, 0, 0), 1'b0, rb());
        push(mk(0, 0, 2, 2, 0, 1, 1, 0, 0, 0, 0), 1'b1, rb());
        push(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), rb(), rb());
        case (kind)
            K_LW: begin
                push(mk(0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0), rb(), rb());
                for (int i = 0; i < mst; i++) push(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1'b0, rb());
                push(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1'b1, rb());
                push(mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0), rb(), rb());
            end
            K_SW, K_MWX: begin
                push(mk(0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0), rb(), rb());
                for (int i = 0; i < mst; i++) push(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0), 1'b0, rb());
                if (kind == K_SW) push(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0), 1'b1, rb());
            end
            K_R, K_I: begin
                push(mk(ealu, 2, (kind == K_I) ? 1 : 0, 0, 0, 0, 0, 0, 0, 0, 0), rb(), rb());
                push(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0), rb(), rb());
            end
            K_BEQ: push(mk(0, 2, 0, 0, 0, 0, int'(bt), 0, 0, 1, 0), rb(), bt);
            K_JAL: begin
                push(mk(0, 1, 2, 0, 0, 0, 1, 0, 0, 0, 0), rb(), rb());
                push(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0), rb(), rb());
            end
            default: for (int i = 0; i < mst; i++) push(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), rb(), rb());
        endcase
        drain(name, o, f3, f7);
        if (kind != K_MWX) begin
            @(posedge clk);
            #1;
            check_eq({name, "_end_cnt"}, instret, model_cnt);
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        memready = 1'b0;
        reset = 1'b0;
        model_cnt = '0;
    endtask

    initial begin
        reset = 1'b1; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
        btaken = 1'b0; memready = 1'b1; model_cnt = '0; cur_imm = 2'b00;
        #12;
        check_eq("rst_out", 32'(obs_now()), 32'(mk(0, 0, 2, 2, 0, 0, 0, 0, 0, 0, 0)));
        check_eq("rst_cnt", instret, 32'd0);
        release_reset();

        run("sub",    K_R,   7'b0110011, 3'b000, 1'b1, 8, 1'b0, 0, 0);
        run("beq_t",  K_BEQ, 7'b1100011, 3'b000, 1'b0, 0, 1'b1, 0, 0);
        run("beq_n",  K_BEQ, 7'b1100011, 3'b000, 1'b0, 0, 1'b0, 0, 0);
        run("lw",     K_LW,  7'b0000011, 3'b010, 1'b0, 0, 1'b0, 2, 3);
        run("sw",     K_SW,  7'b0100011, 3'b010, 1'b0, 0, 1'b0, 0, 2);
        run("slti",   K_I,   7'b0010011, 3'b010, 1'b0, 2, 1'b0, 0, 0);
        run("addi",   K_I,   7'b0010011, 3'b000, 1'b1, 0, 1'b0, 0, 0);
        run("or",     K_R,   7'b0110011, 3'b110, 1'b0, 6, 1'b0, 1, 0);
        run("andi",   K_I,   7'b0010011, 3'b111, 1'b0, 7, 1'b0, 0, 0);
        run("add",    K_R,   7'b0110011, 3'b000, 1'b0, 0, 1'b0, 0, 0);
        run("jal",    K_JAL, 7'b1101111, 3'b000, 1'b0, 0, 1'b0, 0, 0);

        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        model_cnt = 32'hFFFF_FFFF;
        run("wrap",   K_BEQ, 7'b1100011, 3'b000, 1'b0, 0, 1'b1, 0, 0);

        run("sw_rst", K_MWX, 7'b0100011, 3'b010, 1'b0, 0, 1'b0, 0, 1);
        #2;
        reset = 1'b1;
        #1;
        cur_imm = 2'b01;
        check_eq("arst_out", 32'(obs_now()), 32'(mk(0, 0, 2, 2, 0, 0, 0, 0, 0, 0, 0)));
        check_eq("arst_cnt", instret, 32'd0);
        release_reset();
        run("add_post", K_R, 7'b0110011, 3'b000, 1'b0, 0, 1'b0, 0, 0);

        run("ill_f3", K_ILL, 7'b0010011, 3'b001, 1'b0, 0, 1'b0, 0, 12);
        reset = 1'b1;
        release_reset();
        run("ill_op", K_ILL, 7'b1111111, 3'b000, 1'b0, 0, 1'b0, 1, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
